// File: rtl/multichannel_avg_filter.sv
// Multi-channel boxcar (moving-average) filter: 2^N-deep history per channel,
// full-precision running sums, warm-up ramp, synchronous clear and bypass.
module multichannel_avg_filter #(
  parameter int W  = 24,
  parameter int N  = 5,
  parameter int CH = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic [CH*W-1:0] rd_data,
  input  logic          bypass,
  input  logic          clear,
  output logic          read,
  output logic          write,
  output logic [CH*W-1:0] wr_data,
  output logic          primed
);

  localparam int DEPTH = 1 << N;
  localparam int AW    = W + N;
  localparam logic [N:0] FULL = (N+1)'(1) << N;

  logic [N-1:0]          ptr_q, ptr_d;
  logic [N:0]            cnt_q, cnt_d;
  logic                  primed_q, primed_d;
  logic                  write_q, write_d;
  logic [CH*W-1:0]       wr_q, wr_d;
  logic signed [AW-1:0]  acc_q [CH];
  logic signed [AW-1:0]  acc_d [CH];
  logic signed [AW-1:0]  sum_c [CH];
  logic signed [AW-1:0]  avg_c [CH];
  logic [W-1:0]          x_c   [CH];
  logic [W-1:0]          old_c [CH];
  logic [W-1:0]          hist_q [CH][DEPTH];

  assign read    = en;
  assign write   = write_q;
  assign wr_data = wr_q;
  assign primed  = primed_q;

  always_comb begin
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    write_d = 1'b0;
    wr_d    = wr_q;
    for (int unsigned c = 0; c < CH; c++) begin
      acc_d[c] = acc_q[c];
      x_c[c]   = rd_data[c*W +: W];
      // Evict nothing until the window is full so the warm-up output ramps.
      old_c[c] = primed_q ? hist_q[c][ptr_q] : '0;
      sum_c[c] = acc_q[c] + {{N{x_c[c][W-1]}}, x_c[c]}
                          - {{N{old_c[c][W-1]}}, old_c[c]};
      avg_c[c] = sum_c[c] >>> N;
    end

    if (clear) begin
      ptr_d = '0;
      cnt_d = '0;
      wr_d  = '0;
      for (int unsigned c = 0; c < CH; c++) acc_d[c] = '0;
    end else if (en) begin
      ptr_d = ptr_q + 1'b1;
      cnt_d = (cnt_q == FULL) ? cnt_q : cnt_q + 1'b1;
      for (int unsigned c = 0; c < CH; c++) begin
        acc_d[c] = sum_c[c];
        wr_d[c*W +: W] = bypass ? x_c[c] : avg_c[c][W-1:0];
      end
      write_d = (cnt_d == FULL) | bypass;
    end

    primed_d = (cnt_d == FULL);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q    <= '0;
      cnt_q    <= '0;
      primed_q <= 1'b0;
      write_q  <= 1'b0;
      wr_q     <= '0;
      for (int unsigned c = 0; c < CH; c++) acc_q[c] <= '0;
    end else begin
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      primed_q <= primed_d;
      write_q  <= write_d;
      wr_q     <= wr_d;
      for (int unsigned c = 0; c < CH; c++) acc_q[c] <= acc_d[c];
    end
  end

  // History is never reset or bulk-cleared; stale entries are masked by primed.
  always_ff @(posedge clk) begin
    if (en && !clear) begin
      for (int unsigned c = 0; c < CH; c++) hist_q[c][ptr_q] <= x_c[c];
    end
  end

endmodule

// File: tb/tb_multichannel_avg_filter.sv
// Scoreboard bench for multichannel_avg_filter (W=24, N=3, CH=2) against a
// software boxcar model built from the list of samples since reset/clear.
module tb_multichannel_avg_filter;

  localparam int W  = 24;
  localparam int N  = 3;
  localparam int CH = 2;
  localparam int WIN = 1 << N;

  logic          clk;
  logic          reset;
  logic          en;
  logic [CH*W-1:0] rd_data;
  logic          bypass;
  logic          clear;
  logic          read;
  logic          write;
  logic [CH*W-1:0] wr_data;
  logic          primed;

  multichannel_avg_filter #(.W(W), .N(N), .CH(CH)) dut (
    .clk(clk), .reset(reset), .en(en), .rd_data(rd_data), .bypass(bypass),
    .clear(clear), .read(read), .write(write), .wr_data(wr_data), .primed(primed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [CH*W-1:0] data;
    logic            wr;
    logic            pr;
  } exp_t;

  exp_t            sb[$];
  longint          h0[$];
  longint          h1[$];
  logic [CH*W-1:0] last_wr;
  int              n_cmp = 0;
  int              n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic longint win_avg(input int ch);
    longint s = 0;
    int     sz = (ch == 0) ? h0.size() : h1.size();
    int     k  = (sz < WIN) ? sz : WIN;
    for (int i = sz - k; i < sz; i++) s += (ch == 0) ? h0[i] : h1[i];
    return s >>> N;
  endfunction

  function automatic logic [CH*W-1:0] pack(input longint a, input longint b);
    logic [63:0] ua = a;
    logic [63:0] ub = b;
    return {ub[W-1:0], ua[W-1:0]};
  endfunction

  task automatic model_reset();
    h0.delete();
    h1.delete();
    last_wr = '0;
  endtask

  task automatic accept(input longint x0, input longint x1, input bit bp);
    exp_t e, g;
    @(negedge clk);
    en = 1'b1; bypass = bp; clear = 1'b0;
    rd_data = pack(x0, x1);
    h0.push_back(x0);
    h1.push_back(x1);
    e.pr   = (h0.size() >= WIN);
    e.wr   = e.pr | bp;
    e.data = bp ? pack(x0, x1) : pack(win_avg(0), win_avg(1));
    sb.push_back(e);
    #1 check("read", 64'(read), 64'(1));
    @(posedge clk);
    #1;
    en = 1'b0;
    g = sb.pop_front();
    check("wr_data", 64'(wr_data), 64'(g.data));
    check("write", 64'(write), 64'(g.wr));
    check("primed", 64'(primed), 64'(g.pr));
    last_wr = g.data;
  endtask

  task automatic idle();
    @(negedge clk);
    en = 1'b0; clear = 1'b0;
    rd_data = $urandom;
    #1 check("read_idle", 64'(read), 64'(0));
    @(posedge clk);
    #1;
    check("hold_data", 64'(wr_data), 64'(last_wr));
    check("hold_write", 64'(write), 64'(0));
    check("hold_primed", 64'(primed), 64'(h0.size() >= WIN));
  endtask

  task automatic do_clear(input bit with_en);
    @(negedge clk);
    en = with_en; clear = 1'b1; bypass = 1'b0;
    rd_data = pack(5, -5);
    #1 check("read_clr", 64'(read), 64'(with_en));
    @(posedge clk);
    #1;
    en = 1'b0; clear = 1'b0;
    model_reset();
    check("clr_data", 64'(wr_data), 64'(0));
    check("clr_write", 64'(write), 64'(0));
    check("clr_primed", 64'(primed), 64'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    logic signed [W-1:0] r0, r1;
    reset = 1'b0; en = 1'b0; rd_data = '0; bypass = 1'b0; clear = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_data", 64'(wr_data), 64'(0));
    check("rst_write", 64'(write), 64'(0));
    check("rst_primed", 64'(primed), 64'(0));
    @(negedge clk); reset = 1'b1;

    // Ramp, plateau, then decay.
    for (int i = 0; i < 10; i++) accept(8, -16, 1'b0);
    for (int i = 0; i < 10; i++) accept(0, 0, 1'b0);

    // Precision: sub-window values survive the full-precision sum.
    do_clear(1'b1);
    for (int i = 0; i < 8; i++) accept(1, 1, 1'b0);
    for (int i = 0; i < 8; i++) accept(-1, -1, 1'b0);

    // Extremes of the 24-bit range.
    do_clear(1'b0);
    for (int i = 0; i < 8; i++) accept(64'sh7FFFFF, -64'sh800000, 1'b0);
    for (int i = 0; i < 8; i++) accept(-64'sh800000, 64'sh7FFFFF, 1'b0);

    // Gapped random stream, several pointer wraps.
    do_clear(1'b0);
    for (int i = 0; i < 40; i++) begin
      r0 = W'($urandom);
      r1 = W'($urandom);
      accept(longint'(r0), longint'(r1), 1'b0);
      idle();
    end

    // Clear arriving with a sample: that sample is dropped, warm-up restarts.
    do_clear(1'b0);
    for (int i = 0; i < 4; i++) accept(40, -24, 1'b0);
    do_clear(1'b1);
    for (int i = 0; i < 8; i++) accept(16, -32, 1'b0);

    // Asynchronous reset mid-cycle.
    for (int i = 0; i < 3; i++) accept(80, 80, 1'b0);
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    check("arst_data", 64'(wr_data), 64'(0));
    check("arst_write", 64'(write), 64'(0));
    check("arst_primed", 64'(primed), 64'(0));
    model_reset();
    @(negedge clk); reset = 1'b1;
    for (int i = 0; i < 9; i++) accept(24, -8, 1'b0);

    // Bypass during warm-up, then averaging resumes without re-ramp.
    do_clear(1'b0);
    for (int i = 0; i < 8; i++) accept(100, 100, 1'b1);
    for (int i = 0; i < 3; i++) accept(100, 100, 1'b0);
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multichannel_avg_filter.md
Name: multichannel_avg_filter

Overview:
Parametrised multi-channel boxcar (moving-average) filter for the audio path. It sits between the codec read FIFO and the codec write FIFO. Each channel keeps a 2^N-deep circular history and a full-precision running sum, so no precision is lost to a pre-shift of the input. Over the single-channel filter it adds a channel count, full-precision accumulation, a warm-up (primed) indication, a synchronous clear and a bypass mode.

Parameters:
W, 24, sample width in bits (signed two's complement)
N, 5, log2 of averaging window (window = 2^N samples), N >= 1
CH, 2, channel count (2 = left/right)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset (asserted when 0)
en  input  1  sample strobe: one frame (all CH channels) accepted this cycle
rd_data  input  CH*W  packed input frame, channel c at bits [c*W +: W], signed
bypass  input  1  1 = pass input straight through (registered), no averaging on output
clear  input  1  synchronous flush of history and sums
read  output  1  pop request to codec read FIFO
write  output  1  push strobe to codec write FIFO
wr_data  output  CH*W  packed averaged output frame, same packing as rd_data
primed  output  1  1 once 2^N frames have been accepted since reset/clear

Behaviour:
- read = en (combinational).
- Storage per channel: 2^N x W history buffer, shared write pointer ptr (N bits), fill counter cnt (N+1 bits, saturates at 2^N), accumulator acc_c (W+N bits, signed).
- On en, clear=0, per channel c:
  - old_c = primed ? hist_c[ptr] : 0
  - acc_c <= acc_c + sext(x_c) - sext(old_c)
  - hist_c[ptr] <= x_c
- Also on that accept: ptr <= ptr+1 (wraps 2^N-1 -> 0); cnt <= min(cnt+1, 2^N).
- primed = (cnt == 2^N), registered. It goes high on the cycle after the 2^N-th accept.
- Normal mode output: wr_data_c <= (acc_c + sext(x_c) - sext(old_c)) >>> N (arithmetic shift, truncation toward -inf), registered on the same edge as acc. The output is therefore the new window average, 1-cycle latency from en.
- Warm-up: evicted value is forced to 0 while not primed, so the sum holds only the received samples and the output ramps. History RAM is never bulk-cleared.
- write: registered, write <= en & (primed_next | bypass), where primed_next is the cnt value after this accept. It is high the cycle after the accept whose result completes the window, then once per accept thereafter.
- Bypass mode: on en, wr_data <= rd_data and write pulses 1 cycle later. History, acc, cnt and ptr keep updating, so leaving bypass needs no re-warm-up.
- No en: all state and outputs hold. write = 0.
- clear (sync, en ignored, clear wins):
  - acc, cnt, ptr, primed, write and wr_data <= 0.
  - read still follows en, so a sample popped in the clear cycle is discarded.
- Reset (async, any cycle, mid-window included): acc, cnt, ptr, primed, write and wr_data = 0. History contents are don't-care.
- Range: |acc| <= 2^N * 2^(W-1), so W+N bits never overflow. Output always fits in W bits.
- Channels are fully independent apart from the shared ptr, cnt and strobes.

Test Plan:
- N=3, CH=2: reset, then 10 accepts with ch0=8, ch1=-16.
  - Ch0 reads 1,2,...,8 and ch1 reads -2,-4,...,-16.
  - primed and write first go high after the 8th accept; output then holds at 8 / -16.
  - Then 10 accepts of 0: ch0 decays 7,6,...,0 and ch1 decays -14,...,0.
  - primed stays 1.
- Precision: N=3, input 1 for 8 accepts -> output 1 (a pre-shifted design gives 0). Input -1 for 8 accepts -> output -1.
- Extremes: N=3, W=24.
  - 8 accepts of 24'h7FFFFF -> 24'h7FFFFF.
  - Then 8 of 24'h800000 -> ends at 24'h800000; no wrap glitch in any intermediate value.
- Gapped en (one accept per 2 cycles) plus ptr wrap over more than 3 windows: output matches a software boxcar reference every accept.
  - Outputs hold between accepts; write is only high the cycle after an accept.
- Mid-operation events:
  - clear asserted with en at accept 5 -> next 8 accepts ramp again from 0.
  - Async reset pulse mid-cycle -> all outputs 0 immediately, then a clean warm-up.
- Bypass: during warm-up, bypass=1 with input 100 -> wr_data=100 and write=1 one cycle after each en.
  - After 8 accepts, drop bypass -> average 100 with no re-ramp.
